proc_inflight_drop_unit: RTL and testbench

Parametrised response filter for a processor memory port that supports several outstanding requests. It sits between a memory request queue and the pipeline control (request side) and between the memory response stream and the fetch/memory stage (response side). It counts requests in flight and, on `squash`, marks every in-flight response for silent discard, so control no longer has to track drops itself. It generalises the single-shot drop unit with configurable depth and message width, request throttling, drop statistics and protocol-error detection.

---
 rtl/proc_inflight_drop_unit_pkg.sv | 23 ++
 rtl/proc_inflight_drop_unit_counter.sv | 53 +++++
 rtl/proc_inflight_drop_unit.sv | 152 +++++++++++++++
 tb/tb_proc_inflight_drop_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_inflight_drop_unit_pkg.sv
// ---------------------------------------------------------------------------
// proc_inflight_drop_unit_pkg
//
// Shared sizing helpers for the in-flight drop unit. The unit counts from 0
// up to p_max_inflight inclusive, so its counters need enough bits to hold
// the value p_max_inflight itself, not just p_max_inflight-1.
//
// No typedefs live here: the response message is deliberately left as an
// untyped p_msg_nbits vector so the same unit serves the instruction and
// data memory ports.
// ---------------------------------------------------------------------------
package proc_inflight_drop_unit_pkg;

    // Default configuration matching a 4-byte memory response port.
    localparam int c_default_msg_nbits     = 47;
    localparam int c_default_max_inflight  = 4;

    // Width of a counter that must represent 0 .. max_inflight inclusive.
    function automatic int cnt_nbits(input int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

endpackage : proc_inflight_drop_unit_pkg

// File: rtl/proc_inflight_drop_unit_counter.sv
// ---------------------------------------------------------------------------
// proc_updown_counter
//
// Small up/down counter with a parallel load. Load has priority over
// increment/decrement; a simultaneous increment and decrement cancel out.
// Callers are responsible for never driving dec at zero or inc at the
// maximum value (the drop unit guarantees this through its own gating).
//
// Ports:
//   clk       in   clock, rising-edge
//   reset     in   asynchronous, active-low reset (count returns to 0)
//   inc       in   add one this cycle
//   dec       in   subtract one this cycle
//   load      in   replace count with load_val this cycle
//   load_val  in   value used when load is asserted
//   count     out  current count
// ---------------------------------------------------------------------------
module proc_updown_counter #(
    parameter int p_nbits = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    input  logic               load,
    input  logic [p_nbits-1:0] load_val,
    output logic [p_nbits-1:0] count
);

    localparam logic [p_nbits-1:0] c_one = p_nbits'(1);

    logic [p_nbits-1:0] count_next;

    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_val;
        end else if (inc && !dec) begin
            count_next = count + c_one;
        end else if (dec && !inc) begin
            count_next = count - c_one;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule : proc_updown_counter

// File: rtl/proc_inflight_drop_unit.sv
// ---------------------------------------------------------------------------
// proc_inflight_drop_unit
//
// Response filter for a memory port with several outstanding requests.
// It counts requests in flight and, when squash is raised, marks every
// response still owed for the old path as "to be discarded". Discarded
// responses are accepted from memory and never shown to the pipeline.
//
// Handshake semantics (all ports): a transfer happens on a rising edge
// where val and rdy are both high. val never depends on rdy of the same
// interface; rdy may depend on val only through documented combinational
// paths (req_in_rdy depends on req_out_rdy, istream_rdy on ostream_rdy).
//
// Ports:
//   clk           in   clock, rising-edge
//   reset         in   asynchronous, active-low reset
//   req_in_val    in   request valid from control
//   req_in_rdy    out  request ready to control (low while full)
//   req_out_val   out  request valid to memory request queue
//   req_out_rdy   in   memory request queue ready
//   squash        in   discard responses to all requests issued before now
//   istream_msg   in   response message from memory
//   istream_val   in   response valid from memory
//   istream_rdy   out  response ready to memory
//   ostream_msg   out  filtered response message (wired straight through)
//   ostream_val   out  filtered response valid
//   ostream_rdy   in   pipeline ready
//   inflight      out  outstanding request count
//   drop_pending  out  responses still to discard
//   num_dropped   out  total discarded responses, wraps at 2^32
//   proto_err     out  sticky: a response arrived with nothing in flight
// ---------------------------------------------------------------------------
module proc_inflight_drop_unit
    import proc_inflight_drop_unit_pkg::*;
#(
    parameter  int p_msg_nbits    = c_default_msg_nbits,
    parameter  int p_max_inflight = c_default_max_inflight,
    localparam int c_cnt_nbits    = cnt_nbits(p_max_inflight)
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   req_in_val,
    output logic                   req_in_rdy,
    output logic                   req_out_val,
    input  logic                   req_out_rdy,

    input  logic                   squash,

    input  logic [p_msg_nbits-1:0] istream_msg,
    input  logic                   istream_val,
    output logic                   istream_rdy,

    output logic [p_msg_nbits-1:0] ostream_msg,
    output logic                   ostream_val,
    input  logic                   ostream_rdy,

    output logic [c_cnt_nbits-1:0] inflight,
    output logic [c_cnt_nbits-1:0] drop_pending,
    output logic [31:0]            num_dropped,
    output logic                   proto_err
);

    localparam logic [c_cnt_nbits-1:0] c_max = c_cnt_nbits'(p_max_inflight);

    logic                   full;
    logic                   req_fire;
    logic                   dropping;
    logic                   resp_fire;
    logic                   have_inflight;
    logic                   resp_retire;
    logic                   drop_fire;
    logic [c_cnt_nbits-1:0] squash_load_val;

    // ------------------------------------------------------------------
    // Request throttle. The full test uses the registered count only, so
    // a response freeing a slot this cycle does not let a request through
    // until the next cycle (no bypass path from istream to req_*).
    // ------------------------------------------------------------------
    assign full        = (inflight == c_max);
    assign req_out_val = req_in_val  & ~full;
    assign req_in_rdy  = req_out_rdy & ~full;
    assign req_fire    = req_out_val & req_out_rdy;

    // ------------------------------------------------------------------
    // Response filter. While responses are owed to a squashed path the
    // unit sinks them itself, independent of the pipeline's ready.
    // ------------------------------------------------------------------
    assign dropping    = (drop_pending != '0);
    assign istream_rdy = dropping ? 1'b1 : ostream_rdy;
    assign ostream_val = dropping ? 1'b0 : istream_val;
    assign ostream_msg = istream_msg;

    assign resp_fire   = istream_val & istream_rdy;
    assign drop_fire   = resp_fire & dropping;

    // A response with nothing in flight is a protocol error; it is still
    // consumed, but must not wrap the in-flight count below zero.
    assign have_inflight = (inflight != '0);
    assign resp_retire   = resp_fire & have_inflight;

    // On squash, everything currently in flight is owed to the old path,
    // except a response retiring this very cycle (already handled). A
    // request firing this cycle belongs to the new path, so it is not
    // included. Reloading on every squash cycle makes a held squash
    // idempotent for an unchanged in-flight set.
    assign squash_load_val = inflight - c_cnt_nbits'(resp_retire);

    proc_updown_counter #(
        .p_nbits (c_cnt_nbits)
    ) u_inflight_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (req_fire),
        .dec      (resp_retire),
        .load     (1'b0),
        .load_val ('0),
        .count    (inflight)
    );

    proc_updown_counter #(
        .p_nbits (c_cnt_nbits)
    ) u_drop_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (1'b0),
        .dec      (drop_fire),
        .load     (squash),
        .load_val (squash_load_val),
        .count    (drop_pending)
    );

    // ------------------------------------------------------------------
    // Statistics and error flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_dropped <= '0;
        end else if (drop_fire) begin
            num_dropped <= num_dropped + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            proto_err <= 1'b0;
        end else if (istream_val && !have_inflight) begin
            proto_err <= 1'b1;
        end
    end

endmodule : proc_inflight_drop_unit

// File: tb/tb_proc_inflight_drop_unit.sv
// ---------------------------------------------------------------------------
// tb_proc_inflight_drop_unit
//
// Directed bench for proc_inflight_drop_unit (defaults: 47-bit messages,
// up to 4 requests in flight). Inputs change #1 after the rising edge;
// a monitor on the falling edge pops expected messages from exp_q whenever
// a forwarded response is accepted by the pipeline.
// ---------------------------------------------------------------------------
module tb_proc_inflight_drop_unit;
    import proc_inflight_drop_unit_pkg::*;

    localparam int W    = 47;
    localparam int MAXI = 4;
    localparam int CNT  = cnt_nbits(MAXI);

    logic           clk;
    logic           reset;
    logic           req_in_val;
    logic           req_in_rdy;
    logic           req_out_val;
    logic           req_out_rdy;
    logic           squash;
    logic [W-1:0]   istream_msg;
    logic           istream_val;
    logic           istream_rdy;
    logic [W-1:0]   ostream_msg;
    logic           ostream_val;
    logic           ostream_rdy;
    logic [CNT-1:0] inflight;
    logic [CNT-1:0] drop_pending;
    logic [31:0]    num_dropped;
    logic           proto_err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m;

    proc_inflight_drop_unit #(
        .p_msg_nbits    (W),
        .p_max_inflight (MAXI)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_in_val   (req_in_val),
        .req_in_rdy   (req_in_rdy),
        .req_out_val  (req_out_val),
        .req_out_rdy  (req_out_rdy),
        .squash       (squash),
        .istream_msg  (istream_msg),
        .istream_val  (istream_val),
        .istream_rdy  (istream_rdy),
        .ostream_msg  (ostream_msg),
        .ostream_val  (ostream_val),
        .ostream_rdy  (ostream_rdy),
        .inflight     (inflight),
        .drop_pending (drop_pending),
        .num_dropped  (num_dropped),
        .proto_err    (proto_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_msg();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset && ostream_val && ostream_rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fwd", {17'd0, ostream_msg}, 64'd0);
            end else begin
                chk("fwd_msg", {17'd0, ostream_msg}, {17'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One clock of stimulus. Entered and left at #1 after a rising edge.
    task automatic step(input logic rq, input logic sq, input logic rv, input logic fwd);
        req_in_val  = rq;
        squash      = sq;
        istream_val = rv;
        if (rv) begin
            m = rand_msg();
            istream_msg = m;
            if (fwd) exp_q.push_back(m);
        end
        @(posedge clk);
        #1;
        req_in_val  = 1'b0;
        squash      = 1'b0;
        istream_val = 1'b0;
    endtask

    task automatic issue(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic respond(input int n, input logic fwd);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, fwd);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset       = 1'b0;
        req_in_val  = 1'b0;
        req_out_rdy = 1'b1;
        squash      = 1'b0;
        istream_msg = '0;
        istream_val = 1'b0;
        ostream_rdy = 1'b1;

        // Reset state and pass-through while reset is held.
        #1;
        chk("rst_inflight",  inflight, 0);
        chk("rst_drop",      drop_pending, 0);
        chk("rst_ndrop",     num_dropped, 0);
        chk("rst_proto",     proto_err, 0);
        req_in_val  = 1'b1;
        istream_val = 1'b1;
        #1;
        chk("rst_req_out_val", req_out_val, 1);
        chk("rst_req_in_rdy",  req_in_rdy, 1);
        chk("rst_ostream_val", ostream_val, 1);
        req_out_rdy = 1'b0;
        #1;
        chk("rst_req_in_rdy_follow", req_in_rdy, 0);
        req_out_rdy = 1'b1;
        req_in_val  = 1'b0;
        istream_val = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: three requests, three forwarded responses, with a stall.
        issue(3);
        chk("t1_inflight3", inflight, 3);
        ostream_rdy = 1'b0;
        istream_val = 1'b1;
        istream_msg = rand_msg();
        #1;
        chk("t1_bp_istream_rdy", istream_rdy, 0);
        chk("t1_bp_ostream_val", ostream_val, 1);
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        ostream_rdy = 1'b1;
        chk("t1_bp_inflight", inflight, 3);
        respond(1, 1'b1);
        chk("t1_inflight2", inflight, 2);
        respond(2, 1'b1);
        chk("t1_inflight0", inflight, 0);
        chk("t1_ndrop", num_dropped, 0);

        // 2: throttle at full; no same-cycle bypass.
        issue(4);
        chk("t2_inflight4", inflight, 4);
        req_in_val = 1'b1;
        #1;
        chk("t2_full_rdy", req_in_rdy, 0);
        chk("t2_full_val", req_out_val, 0);
        m = rand_msg();
        istream_msg = m;
        istream_val = 1'b1;
        exp_q.push_back(m);
        #1;
        chk("t2_no_bypass", req_in_rdy, 0);
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        chk("t2_after_resp_inflight", inflight, 3);
        chk("t2_after_resp_rdy", req_in_rdy, 1);
        chk("t2_after_resp_val", req_out_val, 1);
        @(posedge clk);
        #1;
        req_in_val = 1'b0;
        chk("t2_refill", inflight, 4);
        respond(4, 1'b1);
        chk("t2_drain", inflight, 0);

        // 3: squash while a 4th request fires.
        issue(3);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_drop3", drop_pending, 3);
        chk("t3_inflight4", inflight, 4);
        ostream_rdy = 1'b0;
        istream_msg = rand_msg();
        istream_val = 1'b1;
        #1;
        chk("t3_drop_istream_rdy", istream_rdy, 1);
        chk("t3_drop_ostream_val", ostream_val, 0);
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        ostream_rdy = 1'b1;
        chk("t3_drop2", drop_pending, 2);
        respond(2, 1'b0);
        chk("t3_drop0", drop_pending, 0);
        chk("t3_inflight1", inflight, 1);
        chk("t3_ndrop3", num_dropped, 3);
        respond(1, 1'b1);
        chk("t3_inflight0", inflight, 0);

        // 4: squash alongside a forwarded response with two in flight.
        issue(2);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("t4_drop1", drop_pending, 1);
        chk("t4_inflight1", inflight, 1);
        respond(1, 1'b0);
        chk("t4_drop0", drop_pending, 0);
        chk("t4_inflight0", inflight, 0);
        chk("t4_ndrop4", num_dropped, 4);

        // 5: response with nothing in flight.
        chk("t5_proto_before", proto_err, 0);
        respond(1, 1'b1);
        chk("t5_proto_set", proto_err, 1);
        chk("t5_inflight_sat", inflight, 0);
        issue(3);
        chk("t5_proto_sticky", proto_err, 1);

        // 6: reset mid-drop, then normal operation.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_drop3", drop_pending, 3);
        respond(1, 1'b0);
        chk("t6_drop2", drop_pending, 2);
        chk("t6_ndrop5", num_dropped, 5);
        reset = 1'b0;
        #1;
        chk("t6_rst_inflight", inflight, 0);
        chk("t6_rst_drop", drop_pending, 0);
        chk("t6_rst_ndrop", num_dropped, 0);
        chk("t6_rst_proto", proto_err, 0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        issue(1);
        chk("t6_post_inflight1", inflight, 1);
        respond(1, 1'b1);
        chk("t6_post_inflight0", inflight, 0);
        chk("t6_post_ndrop", num_dropped, 0);
        chk("t6_post_proto", proto_err, 0);

        // Every expected forwarded response must have appeared.
        @(posedge clk);
        #1;
        chk("exp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_proc_inflight_drop_unit
